// File: rtl/fetch_unit_pkg.sv
// Shared constants and types for the instruction fetch stage.
package fetch_unit_pkg;

    localparam logic [31:0] FETCH_RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] INSTRUCTION_NOP        = 32'h0000_0013;

    // One buffered instruction together with the address it was fetched from.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } fetch_entry_t;

    // Instruction addresses are word aligned; the low two bits are dropped.
    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_unit_fifo.sv
// Small synchronous FIFO with flush, used for buffered instructions and issue PCs.
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 64,
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic [WIDTH-1:0] data_o,
    output logic [CW-1:0]    count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    // Pointer and occupancy update; flush wins over push and pop.
    always_comb begin
        do_push  = push_i && !flush_i && !full_o;
        do_pop   = pop_i && !flush_i && !empty_o;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are only observed while the FIFO is non-empty.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, in-order memory requests, response buffering
// and a valid/ready instruction port towards the decoder.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = FETCH_RESET_PC_DEFAULT,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] instruction,
    output logic [31:0] inst_pc
);

    localparam int unsigned CW = $clog2(BUF_DEPTH + 1);
    localparam int unsigned SW = CW + 1;

    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] out_q, out_d;
    logic [CW-1:0] drop_q, drop_d;

    logic          issue, resp, resp_keep, pop;
    logic [SW-1:0] in_use;

    fetch_entry_t  data_in, data_head;
    logic [CW-1:0] data_cnt;
    logic          data_full, data_empty;

    logic [31:0]   pcq_head;
    logic [CW-1:0] pcq_cnt;
    logic          pcq_full, pcq_empty;
    logic          unused_status;

    assign unused_status = ^{pcq_cnt, pcq_full, pcq_empty, data_full};

    assign inst_valid = !data_empty;
    assign pop        = inst_valid && inst_ready && !redirect;
    assign resp       = imem_rvalid;
    assign resp_keep  = resp && (drop_q == '0);

    // A slot freed by a same-cycle pop is credited immediately; this is what
    // lets a 1-cycle memory sustain one instruction per cycle with two entries.
    assign in_use    = {1'b0, out_q} + {1'b0, data_cnt} - SW'(pop);
    assign imem_req  = rst_n && !redirect && (in_use < SW'(BUF_DEPTH));
    assign imem_addr = pc_q;
    assign issue     = imem_req && imem_gnt;

    assign data_in     = '{pc: pcq_head, word: imem_rdata};
    assign instruction = inst_valid ? data_head.word : INSTRUCTION_NOP;
    assign inst_pc     = inst_valid ? data_head.pc   : RESET_PC;

    // Next PC, in-flight count and discard count; redirect overrides everything.
    always_comb begin
        pc_d   = pc_q;
        out_d  = out_q + CW'(issue) - CW'(resp);
        drop_d = drop_q;
        if (redirect) begin
            pc_d   = align_pc(redirect_pc);
            drop_d = out_q - CW'(resp);
        end else begin
            if (issue) pc_d = pc_q + 32'd4;
            if (resp && (drop_q != '0)) drop_d = drop_q - CW'(1);
        end
    end

    // Fetch control registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q   <= RESET_PC;
            out_q  <= '0;
            drop_q <= '0;
        end else begin
            pc_q   <= pc_d;
            out_q  <= out_d;
            drop_q <= drop_d;
        end
    end

    fetch_fifo #(
        .DEPTH (BUF_DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_data_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (resp_keep),
        .data_i  (data_in),
        .pop_i   (pop),
        .flush_i (redirect),
        .data_o  (data_head),
        .count_o (data_cnt),
        .full_o  (data_full),
        .empty_o (data_empty)
    );

    fetch_fifo #(
        .DEPTH (BUF_DEPTH),
        .WIDTH (32)
    ) u_pc_queue (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (issue),
        .data_i  (pc_q),
        .pop_i   (resp_keep),
        .flush_i (redirect),
        .data_o  (pcq_head),
        .count_o (pcq_cnt),
        .full_o  (pcq_full),
        .empty_o (pcq_empty)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit with an in-order instruction memory model
// that returns each word's own address as data.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] instruction;
    logic [31:0] inst_pc;

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .BUF_DEPTH (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .instruction (instruction),
        .inst_pc     (inst_pc)
    );

    typedef struct {
        logic        rdy;
        logic        req;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] pc;
    } vec_t;

    vec_t tbl[13];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_pop = 0;

    logic [31:0] mem_addr_q[$];
    int          mem_rdy_q[$];

    bit          rand_gnt   = 1'b0;
    bit          rand_ready = 1'b0;
    logic        ready_fix  = 1'b1;
    int          lat_lo     = 1;
    int          lat_hi     = 1;
    bit          redir_now  = 1'b0;
    logic [31:0] redir_tgt  = 32'h0;

    logic [31:0] exp_pc    = 32'h0;
    logic [31:0] exp_issue = 32'h0;
    bit          hold_prev = 1'b0;
    logic [31:0] hold_pc   = 32'h0;

    logic        s_req, s_valid;
    logic [31:0] s_addr, s_pc, s_inst;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle: drive at the falling edge, sample just before the rising edge.
    task automatic step();
        @(negedge clk);
        imem_gnt = rand_gnt ? ($urandom_range(0, 1) == 1) : 1'b1;
        if (mem_addr_q.size() != 0 && mem_rdy_q[0] <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_addr_q[0];
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'hDEAD_BEEF;
        end
        inst_ready  = rand_ready ? ($urandom_range(0, 3) != 0) : ready_fix;
        redirect    = redir_now;
        redirect_pc = redir_tgt;
        #4;
        s_req   = imem_req;
        s_addr  = imem_addr;
        s_valid = inst_valid;
        s_pc    = inst_pc;
        s_inst  = instruction;
        if (redirect) chk("req_on_redirect", 32'(imem_req), 32'h0);
        if (imem_req && imem_gnt) begin
            chk("issue_addr", imem_addr, exp_issue);
            exp_issue = exp_issue + 32'd4;
            mem_addr_q.push_back(imem_addr);
            mem_rdy_q.push_back(cyc + int'($urandom_range(lat_lo, lat_hi)));
        end
        if (imem_rvalid) begin
            void'(mem_addr_q.pop_front());
            void'(mem_rdy_q.pop_front());
        end
        if (hold_prev && !redirect) begin
            chk("hold_valid", 32'(inst_valid), 32'h1);
            chk("hold_pc", inst_pc, hold_pc);
        end
        if (inst_valid && inst_ready && !redirect) begin
            chk("out_pc", inst_pc, exp_pc);
            chk("out_inst", instruction, exp_pc);
            exp_pc = exp_pc + 32'd4;
            n_pop++;
        end
        hold_prev = inst_valid && !inst_ready && !redirect;
        hold_pc   = inst_pc;
        if (redirect) begin
            exp_pc    = redirect_pc & 32'hFFFF_FFFC;
            exp_issue = redirect_pc & 32'hFFFF_FFFC;
        end
        redir_now = 1'b0;
        cyc++;
    endtask

    // Asynchronous reset pulse; reset values are checked before any clock edge.
    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n       = 1'b0;
        imem_rvalid = 1'b0;
        redirect    = 1'b0;
        redir_now   = 1'b0;
        mem_addr_q.delete();
        mem_rdy_q.delete();
        #1;
        chk("rst_req", 32'(imem_req), 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", 32'(inst_valid), 32'h0);
        chk("rst_inst", instruction, 32'h0000_0013);
        chk("rst_pc", inst_pc, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        exp_pc    = 32'h0;
        exp_issue = 32'h0;
        hold_prev = 1'b0;
        cyc       = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Cycle-exact start-up with a 1-cycle memory, then a 5-cycle decoder stall.
        tbl[0]  = '{1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
        tbl[1]  = '{1'b1, 1'b1, 32'h04, 1'b0, 32'h00};
        tbl[2]  = '{1'b1, 1'b1, 32'h08, 1'b1, 32'h00};
        tbl[3]  = '{1'b1, 1'b1, 32'h0C, 1'b1, 32'h04};
        tbl[4]  = '{1'b1, 1'b1, 32'h10, 1'b1, 32'h08};
        tbl[5]  = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h0C};
        tbl[6]  = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h0C};
        tbl[7]  = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h0C};
        tbl[8]  = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h0C};
        tbl[9]  = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h0C};
        tbl[10] = '{1'b1, 1'b1, 32'h14, 1'b1, 32'h0C};
        tbl[11] = '{1'b1, 1'b1, 32'h18, 1'b1, 32'h10};
        tbl[12] = '{1'b1, 1'b1, 32'h1C, 1'b1, 32'h14};

        do_reset();
        for (int i = 0; i < 13; i++) begin
            ready_fix = tbl[i].rdy;
            step();
            chk($sformatf("tbl%0d_req", i), 32'(s_req), 32'(tbl[i].req));
            if (tbl[i].req) chk($sformatf("tbl%0d_addr", i), s_addr, tbl[i].addr);
            chk($sformatf("tbl%0d_valid", i), 32'(s_valid), 32'(tbl[i].vld));
            if (tbl[i].vld) begin
                chk($sformatf("tbl%0d_pc", i), s_pc, tbl[i].pc);
                chk($sformatf("tbl%0d_inst", i), s_inst, tbl[i].pc);
            end
        end

        // Redirect with two fetches in flight: both late responses are discarded.
        do_reset();
        ready_fix = 1'b1;
        lat_lo = 3;
        lat_hi = 3;
        step();
        step();
        redir_now = 1'b1;
        redir_tgt = 32'h0000_0100;
        step();
        step();
        chk("redir_credit_req", 32'(s_req), 32'h0);
        chk("redir_valid_off", 32'(s_valid), 32'h0);
        n_pop = 0;
        repeat (12) step();
        chk("redir_progress", (n_pop > 0) ? 32'h1 : 32'h0, 32'h1);

        // Unaligned redirect in steady state, coinciding with a response and a pop.
        lat_lo = 1;
        lat_hi = 1;
        repeat (8) step();
        redir_now = 1'b1;
        redir_tgt = 32'h0000_0203;
        step();
        chk("redir_same_cycle_valid", 32'(s_valid), 32'h1);
        step();
        chk("redir203_req", 32'(s_req), 32'h1);
        chk("redir203_addr", s_addr, 32'h0000_0200);
        chk("redir203_valid", 32'(s_valid), 32'h0);
        repeat (6) step();

        // Random grant and memory latency; the scoreboard checks the PC stream.
        rand_gnt   = 1'b1;
        rand_ready = 1'b1;
        lat_lo     = 1;
        lat_hi     = 3;
        n_pop      = 0;
        repeat (150) step();
        redir_now = 1'b1;
        redir_tgt = $urandom & 32'h0000_FFFF;
        repeat (150) step();
        chk("random_progress", (n_pop >= 30) ? 32'h1 : 32'h0, 32'h1);

        // Mid-stream reset, then restart from the reset PC.
        do_reset();
        step();
        chk("restart_req", 32'(s_req), 32'h1);
        chk("restart_addr", s_addr, 32'h0);
        n_pop = 0;
        repeat (100) step();
        chk("restart_progress", (n_pop >= 10) ? 32'h1 : 32'h0, 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
